analog_pad_seq: RTL and testbench

ANALOG_PAD_SEQ -- requirements
Module: analog_pad_seq

---
 rtl/analog_pad_seq.sv | 127 ++++++++++++
 tb/tb_analog_pad_seq.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/analog_pad_seq.sv
// Break-before-make sequencer for a bank of analog pad switches.
// At most one switch is closed; a change opens all switches, waits a dead time, closes, then settles.
module analog_pad_seq #(
  parameter int NUM_CH = 4,
  parameter int CW     = 2,
  parameter int SW     = 8
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              req,
  input  logic [CW-1:0]     req_ch,
  input  logic              req_conn,
  input  logic [3:0]        dead_cyc,
  input  logic [SW-1:0]     settle_cyc,
  output logic [NUM_CH-1:0] sw_en,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CW-1:0]     cur_ch,
  output logic              cur_vld
);

  localparam int CNTW = (SW > 4) ? SW : 4;

  typedef enum logic [2:0] {
    S_IDLE, S_BREAK, S_DEAD, S_MAKE, S_SETTLE, S_DONE
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   lat_ch;
  logic            lat_conn;
  logic            lat_same;
  logic [3:0]      lat_dead;
  logic [SW-1:0]   lat_settle;
  logic [CNTW-1:0] cnt;
  logic            err_defer;

  logic            bad_ch;
  logic            same_ch;
  logic            accept;
  logic            drop;
  logic [3:0]      dead_last;
  logic [SW-1:0]   settle_last;

  function automatic logic [NUM_CH-1:0] onehot(input logic [CW-1:0] ch);
    onehot = {{(NUM_CH-1){1'b0}}, 1'b1} << ch;
  endfunction

  assign bad_ch  = req_conn && (int'(req_ch) >= NUM_CH);
  assign same_ch = req_conn && cur_vld && (req_ch == cur_ch);
  assign accept  = (state == S_IDLE) && req && !bad_ch;
  assign drop    = req && !accept;

  // Terminal counts are last-cycle indices; a zero dead time still costs one cycle.
  assign dead_last   = (lat_dead == 4'd0) ? 4'd0 : lat_dead - 4'd1;
  assign settle_last = (lat_settle == '0) ? '0 : lat_settle - 1'b1;

  always_comb begin
    state_nxt = state;
    case (state)
      // Re-selecting the connected channel skips the break and passes through MAKE
      // with the same switch closed, so the switch pattern never changes.
      S_IDLE:   if (accept) state_nxt = same_ch ? S_MAKE : S_BREAK;
      S_BREAK:  state_nxt = lat_conn ? S_DEAD : S_DONE;
      S_DEAD:   if (cnt >= CNTW'(dead_last)) state_nxt = S_MAKE;
      S_MAKE:   state_nxt = (lat_same || lat_settle == '0) ? S_DONE : S_SETTLE;
      S_SETTLE: if (cnt >= CNTW'(settle_last)) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state      <= S_IDLE;
      lat_ch     <= '0;
      lat_conn   <= 1'b0;
      lat_same   <= 1'b0;
      lat_dead   <= '0;
      lat_settle <= '0;
      cnt        <= '0;
      cur_vld    <= 1'b0;
      cur_ch     <= '0;
      err        <= 1'b0;
      err_defer  <= 1'b0;
    end else begin
      state <= state_nxt;

      if (state_nxt == state && (state == S_DEAD || state == S_SETTLE))
        cnt <= (cnt != '1) ? cnt + 1'b1 : cnt;
      else
        cnt <= '0;

      if (accept) begin
        lat_ch     <= req_ch;
        lat_conn   <= req_conn;
        lat_same   <= same_ch;
        lat_dead   <= dead_cyc;
        lat_settle <= settle_cyc;
        if (!same_ch) cur_vld <= 1'b0;
      end

      if (state_nxt == S_DONE && state != S_DONE && lat_conn) begin
        cur_vld <= 1'b1;
        cur_ch  <= lat_ch;
      end

      // An err that would land on the done cycle is pushed one cycle later.
      err       <= (drop && state_nxt != S_DONE) || err_defer;
      err_defer <= drop && state_nxt == S_DONE;
    end
  end

  always_comb begin
    sw_en = '0;
    case (state)
      S_IDLE:            sw_en = cur_vld ? onehot(cur_ch) : '0;
      S_MAKE, S_SETTLE:  sw_en = onehot(lat_ch);
      S_DONE:            sw_en = lat_conn ? onehot(lat_ch) : '0;
      default:           sw_en = '0;
    endcase
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_analog_pad_seq.sv
// Directed bench for analog_pad_seq with a continuous switch-safety monitor.
module tb_analog_pad_seq;
  localparam int NUM_CH = 5;
  localparam int CW     = 3;
  localparam int SW     = 8;

  logic              pclk = 1'b0;
  logic              preset = 1'b1;
  logic              req = 1'b0;
  logic [CW-1:0]     req_ch = '0;
  logic              req_conn = 1'b0;
  logic [3:0]        dead_cyc = '0;
  logic [SW-1:0]     settle_cyc = '0;
  logic [NUM_CH-1:0] sw_en;
  logic              busy, done, err, cur_vld;
  logic [CW-1:0]     cur_ch;

  int total = 0;
  int bad   = 0;

  analog_pad_seq #(.NUM_CH(NUM_CH), .CW(CW), .SW(SW)) dut (
    .pclk(pclk), .preset(preset), .req(req), .req_ch(req_ch), .req_conn(req_conn),
    .dead_cyc(dead_cyc), .settle_cyc(settle_cyc), .sw_en(sw_en), .busy(busy),
    .done(done), .err(err), .cur_ch(cur_ch), .cur_vld(cur_vld)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // Request held for one cycle; afterwards the timing inputs are scrambled so
  // that only the values latched at acceptance can produce the right timing.
  task automatic issue(input int ch, input bit conn, input int dead, input int settle);
    req        = 1'b1;
    req_ch     = CW'(ch);
    req_conn   = conn;
    dead_cyc   = 4'(dead);
    settle_cyc = SW'(settle);
    tick();
    req        = 1'b0;
    dead_cyc   = 4'hF;
    settle_cyc = '1;
  endtask

  logic              mon_en = 1'b0;
  logic [NUM_CH-1:0] prev_sw = '0;
  logic              fell_prev = 1'b0;
  logic              rise, fell;

  always @(negedge pclk) begin
    if (mon_en) begin
      rise = |(~prev_sw & sw_en);
      fell = |(prev_sw & ~sw_en);
      chk("onehot", 32'($countones(sw_en) <= 1), 1);
      chk("break_before_make", 32'(rise && (fell || fell_prev)), 0);
      chk("done_err_excl", 32'(done && err), 0);
      fell_prev = fell;
      prev_sw   = sw_en;
    end
  end

  initial begin
    int seen_done;

    // Reset state
    tick(); tick();
    chk("rst_sw", sw_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_vld", cur_vld, 0);
    chk("rst_ch", cur_ch, 0);
    preset = 1'b0;
    mon_en = 1'b1;
    tick();

    // Connect ch 2, dead 3, settle 5: make at cycle 5, done at cycle 11
    issue(2, 1'b1, 3, 5);
    chk("c2_c1_sw", sw_en, 0);
    chk("c2_c1_busy", busy, 1);
    chk("c2_c1_vld", cur_vld, 0);
    for (int c = 2; c <= 11; c++) begin
      tick();
      chk($sformatf("c2_sw_%0d", c), sw_en, (c >= 5) ? 5'b00100 : 5'b00000);
      chk($sformatf("c2_done_%0d", c), done, (c == 11) ? 1 : 0);
    end
    chk("c2_vld", cur_vld, 1);
    chk("c2_ch", cur_ch, 2);
    tick();
    chk("c2_idle_busy", busy, 0);
    chk("c2_idle_sw", sw_en, 5'b00100);
    chk("c2_idle_vld", cur_vld, 1);

    // Switch to ch 1 with dead 0 and settle 0: two open cycles, done at cycle 4
    issue(1, 1'b1, 0, 0);
    chk("c1_sw_1", sw_en, 0);
    tick();
    chk("c1_sw_2", sw_en, 0);
    chk("c1_done_2", done, 0);
    tick();
    chk("c1_sw_3", sw_en, 5'b00010);
    chk("c1_done_3", done, 0);
    tick();
    chk("c1_done_4", done, 1);
    chk("c1_sw_4", sw_en, 5'b00010);
    chk("c1_ch_4", cur_ch, 1);
    chk("c1_vld_4", cur_vld, 1);
    tick();

    // Connect ch 3 (dead 2, settle 1 -> done at 6) with an intruding request at cycle 2
    issue(3, 1'b1, 2, 1);
    tick();
    req = 1'b1; req_ch = 3'd0; req_conn = 1'b1;
    tick();
    req = 1'b0;
    chk("busy_err_3", err, 1);
    chk("busy_sw_3", sw_en, 0);
    chk("busy_busy_3", busy, 1);
    for (int c = 4; c <= 6; c++) begin
      tick();
      chk($sformatf("busy_sw_%0d", c), sw_en, 5'b01000);
      chk($sformatf("busy_done_%0d", c), done, (c == 6) ? 1 : 0);
      chk($sformatf("busy_err_%0d", c), err, 0);
    end
    chk("busy_ch", cur_ch, 3);
    tick();

    // Re-select connected ch 3: no break, done two cycles after req;
    // a request in the cycle before done has its err moved past the done pulse
    issue(3, 1'b1, 0, 0);
    chk("same_busy_1", busy, 1);
    chk("same_sw_1", sw_en, 5'b01000);
    chk("same_vld_1", cur_vld, 1);
    req = 1'b1; req_ch = 3'd1;
    tick();
    req = 1'b0;
    chk("same_done_2", done, 1);
    chk("same_err_2", err, 0);
    chk("same_sw_2", sw_en, 5'b01000);
    tick();
    chk("same_err_3", err, 1);
    chk("same_busy_3", busy, 0);
    chk("same_done_3", done, 0);

    // Out-of-range channels are rejected without touching the switches
    issue(5, 1'b1, 0, 0);
    chk("badch5_err", err, 1);
    chk("badch5_busy", busy, 0);
    chk("badch5_sw", sw_en, 5'b01000);
    issue(7, 1'b1, 0, 0);
    chk("badch7_err", err, 1);
    chk("badch7_vld", cur_vld, 1);
    tick();
    chk("badch_err_clr", err, 0);

    // Disconnect, then disconnect again with nothing connected
    issue(0, 1'b0, 0, 0);
    chk("disc_sw_1", sw_en, 0);
    chk("disc_vld_1", cur_vld, 0);
    chk("disc_done_1", done, 0);
    tick();
    chk("disc_done_2", done, 1);
    chk("disc_sw_2", sw_en, 0);
    tick();
    chk("disc_busy_3", busy, 0);
    issue(0, 1'b0, 0, 0);
    chk("disc2_busy_1", busy, 1);
    tick();
    chk("disc2_done_2", done, 1);
    chk("disc2_vld_2", cur_vld, 0);
    tick();

    // Reset during SETTLE abandons the request
    issue(4, 1'b1, 1, 10);
    for (int c = 2; c <= 6; c++) begin
      tick();
      chk($sformatf("rs_sw_%0d", c), sw_en, (c >= 3) ? 5'b10000 : 5'b00000);
    end
    preset = 1'b1;
    tick();
    chk("rs_sw", sw_en, 0);
    chk("rs_busy", busy, 0);
    chk("rs_done", done, 0);
    chk("rs_vld", cur_vld, 0);
    preset = 1'b0;
    seen_done = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (done) seen_done++;
    end
    chk("rs_no_done", seen_done, 0);

    // Random traffic under the safety monitor
    for (int c = 0; c < 400; c++) begin
      req        = ($urandom_range(0, 3) == 0);
      req_ch     = CW'($urandom_range(0, 7));
      req_conn   = ($urandom_range(0, 3) != 0);
      dead_cyc   = 4'($urandom_range(0, 3));
      settle_cyc = SW'($urandom_range(0, 4));
      preset     = ($urandom_range(0, 99) == 0);
      tick();
    end
    preset = 1'b0;
    req    = 1'b0;
    for (int c = 0; c < 50 && busy; c++) tick();
    chk("drain_idle", busy, 0);

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
